// File: rtl/dm_hart_array_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dm
// Purpose  : Shared types and helpers for the debug-module multi-hart
//            run-control engine: per-hart state encoding, the dmstatus
//            summary struct and any/all reduction helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dm;

  localparam int MaxHarts = 32;

  typedef enum logic [1:0] {
    Running    = 2'd0,
    Halted     = 2'd1,
    ResumePend = 2'd2
  } hart_state_e;

  // Field order matches dmstatus bits 19..8, so the struct can be dropped
  // straight into the CSR image.
  typedef struct packed {
    logic allhavereset;
    logic anyhavereset;
    logic allresumeack;
    logic anyresumeack;
    logic allnonexistent;
    logic anynonexistent;
    logic allunavail;
    logic anyunavail;
    logic allrunning;
    logic anyrunning;
    logic allhalted;
    logic anyhalted;
  } hart_status_t;

  function automatic logic any_of(input logic [MaxHarts-1:0] x,
                                  input logic [MaxHarts-1:0] s);
    return |(x & s);
  endfunction

  // Unselected positions read as 1 so they never veto "all"; an empty
  // selection reports 0.
  function automatic logic all_of(input logic [MaxHarts-1:0] x,
                                  input logic [MaxHarts-1:0] s);
    return (&(x | ~s)) & (|s);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_hart_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dm_hart_ctrl
// Purpose  : Run-control state for one hart slot: RUNNING/HALTED/RESUME_PEND
//            FSM, resume request hold, sticky resumeack and havereset.
// Ports    : i_clk, i_rst_n      - clock, asynchronous active-low reset
//            i_clear             - synchronous soft clear (DM inactive)
//            i_sel               - hart is in the current selection
//            i_haltreq           - halt request level
//            i_resumereq         - resume request pulse
//            i_ackhavereset      - havereset acknowledge pulse
//            i_halted            - hart is in debug mode
//            i_resuming          - hart left debug mode (pulse)
//            i_hart_reset        - hart came out of reset (pulse)
//            o_resumereq         - registered resume request to debug memory
//            o_resumeack         - sticky resume acknowledge
//            o_havereset         - sticky have-reset flag
// Revision : 1.0 - initial release
// ============================================================================
module dm_hart_ctrl
  import dm::*;
#(
  parameter logic SELECTABLE = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_sel,
  input  logic i_haltreq,
  input  logic i_resumereq,
  input  logic i_ackhavereset,
  input  logic i_halted,
  input  logic i_resuming,
  input  logic i_hart_reset,
  output logic o_resumereq,
  output logic o_resumeack,
  output logic o_havereset
);

  hart_state_e r_state;
  logic        r_resumereq;
  logic        r_resumeack;
  logic        r_havereset;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= Running;
      r_resumereq <= 1'b0;
      r_resumeack <= 1'b0;
      r_havereset <= SELECTABLE;
    end else if (i_clear) begin
      r_state     <= Running;
      r_resumereq <= 1'b0;
      r_resumeack <= 1'b0;
      r_havereset <= SELECTABLE;
    end else begin
      case (r_state)
        Running: begin
          if (i_halted) begin
            r_state <= Halted;
          end
        end
        Halted: begin
          // A concurrent halt request takes priority over resume.
          if (i_resumereq && i_sel && !i_haltreq) begin
            r_state     <= ResumePend;
            r_resumeack <= 1'b0;
            r_resumereq <= 1'b1;
          end else if (!i_halted) begin
            // Left debug mode without a resume: the hart was reset.
            r_state <= Running;
          end
        end
        ResumePend: begin
          if (i_resuming) begin
            r_state     <= Running;
            r_resumeack <= 1'b1;
            r_resumereq <= 1'b0;
          end
        end
        default: begin
          r_state     <= Running;
          r_resumereq <= 1'b0;
        end
      endcase

      // A fresh reset must not be lost to an acknowledge in the same cycle.
      if (i_hart_reset) begin
        r_havereset <= 1'b1;
      end else if (i_ackhavereset && i_sel) begin
        r_havereset <= 1'b0;
      end
    end
  end

  assign o_resumereq = r_resumereq;
  assign o_resumeack = r_resumeack;
  assign o_havereset = r_havereset;

endmodule
`default_nettype wire

// File: rtl/dm_hart_array.sv
`default_nettype none
// ============================================================================
// Module   : dm_hart_array
// Purpose  : Multi-hart run-control engine between the DM CSR block and the
//            per-hart debug memory. Resolves hartsel / hart-array-window
//            selection, issues halt and resume requests, runs a halt-timeout
//            watchdog and produces registered dmstatus summary flags.
// Ports    : clk_i, rst_ni        - clock, asynchronous active-low reset
//            dmactive_i           - DM active; low is a synchronous clear
//            hartsel_i/hasel_i/hawindow_i - hart selection
//            haltreq_i, resumereq_i, ackhavereset_i - dmcontrol requests
//            halted_i, resuming_i, unavailable_i, hart_reset_i - hart status
//            debug_req_o, resumereq_o - per-hart requests
//            sel_o                - current selection vector
//            halt_timeout_o       - sticky watchdog flag
//            status_o             - any/all summary flags
// Revision : 1.0 - initial release
// ============================================================================
module dm_hart_array
  import dm::*;
#(
  parameter int                 NrHarts         = 1,
  parameter logic [NrHarts-1:0] SelectableHarts = '1,
  parameter int                 HaltTimeout     = 1024,
  parameter int                 CntWidth        = (HaltTimeout > 0) ? $clog2(HaltTimeout + 1) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               dmactive_i,
  input  logic [19:0]        hartsel_i,
  input  logic               hasel_i,
  input  logic [NrHarts-1:0] hawindow_i,
  input  logic               haltreq_i,
  input  logic               resumereq_i,
  input  logic               ackhavereset_i,
  input  logic [NrHarts-1:0] halted_i,
  input  logic [NrHarts-1:0] resuming_i,
  input  logic [NrHarts-1:0] unavailable_i,
  input  logic [NrHarts-1:0] hart_reset_i,
  output logic [NrHarts-1:0] debug_req_o,
  output logic [NrHarts-1:0] resumereq_o,
  output logic [NrHarts-1:0] sel_o,
  output logic               halt_timeout_o,
  output hart_status_t       status_o
);

  logic [NrHarts-1:0] w_single;
  logic [NrHarts-1:0] w_sel;
  logic [NrHarts-1:0] w_resumeack;
  logic [NrHarts-1:0] w_havereset;
  logic [NrHarts-1:0] w_pending;
  logic               w_nonexistent;
  logic               w_clear;
  logic               w_wd_active;
  hart_status_t       w_status;
  hart_status_t       r_status;

  assign w_clear = ~dmactive_i;

  // --------------------------------------------------------------------------
  // Selection. An out-of-range hartsel matches no slot, which also makes it
  // read as nonexistent without indexing past the parameter width.
  // --------------------------------------------------------------------------
  for (genvar h = 0; h < NrHarts; h++) begin : g_sel
    assign w_single[h] = (hartsel_i == 20'(h));
    assign w_sel[h]    = SelectableHarts[h] & (w_single[h] | (hasel_i & hawindow_i[h]));
  end

  assign w_nonexistent = ~|(w_single & SelectableHarts);
  assign sel_o         = w_sel;

  // Harts still owed a halt: selected, not yet in debug mode, and reachable.
  assign w_pending   = w_sel & ~halted_i & ~unavailable_i;
  assign debug_req_o = {NrHarts{dmactive_i & haltreq_i}} & w_pending;

  // --------------------------------------------------------------------------
  // Per-hart run control
  // --------------------------------------------------------------------------
  for (genvar h = 0; h < NrHarts; h++) begin : g_hart
    dm_hart_ctrl #(
      .SELECTABLE (SelectableHarts[h])
    ) u_hart_ctrl (
      .i_clk          (clk_i),
      .i_rst_n        (rst_ni),
      .i_clear        (w_clear),
      .i_sel          (w_sel[h]),
      .i_haltreq      (haltreq_i),
      .i_resumereq    (resumereq_i),
      .i_ackhavereset (ackhavereset_i),
      .i_halted       (halted_i[h]),
      .i_resuming     (resuming_i[h]),
      .i_hart_reset   (hart_reset_i[h]),
      .o_resumereq    (resumereq_o[h]),
      .o_resumeack    (w_resumeack[h]),
      .o_havereset    (w_havereset[h])
    );
  end

  // --------------------------------------------------------------------------
  // Halt-timeout watchdog
  // --------------------------------------------------------------------------
  assign w_wd_active = haltreq_i & (|w_pending);

  if (HaltTimeout > 0) begin : g_wdog
    localparam logic [CntWidth-1:0] c_LIMIT = CntWidth'(HaltTimeout);

    logic [CntWidth-1:0] r_cnt;
    logic [CntWidth-1:0] w_cnt_nxt;
    logic                r_timeout;

    // Saturate at the limit so a long-stuck request never wraps the count.
    always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_wd_active && (r_cnt != c_LIMIT)) begin
        w_cnt_nxt = r_cnt + CntWidth'(1);
      end
    end

    // The flag is raised on the same edge the count reaches the limit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_cnt     <= '0;
        r_timeout <= 1'b0;
      end else if (w_clear || !haltreq_i) begin
        r_cnt     <= '0;
        r_timeout <= 1'b0;
      end else begin
        r_cnt <= w_cnt_nxt;
        if (w_cnt_nxt == c_LIMIT) begin
          r_timeout <= 1'b1;
        end
      end
    end

    assign halt_timeout_o = r_timeout;
  end else begin : g_no_wdog
    assign halt_timeout_o = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Status reduction over the current selection, registered once.
  // --------------------------------------------------------------------------
  always_comb begin
    logic [MaxHarts-1:0] v_s;
    logic [MaxHarts-1:0] v_halted;
    logic [MaxHarts-1:0] v_running;
    logic [MaxHarts-1:0] v_unavail;
    logic [MaxHarts-1:0] v_ack;
    logic [MaxHarts-1:0] v_hrst;

    v_s       = MaxHarts'(w_sel);
    v_halted  = MaxHarts'(halted_i);
    v_running = MaxHarts'(~halted_i & ~unavailable_i);
    v_unavail = MaxHarts'(unavailable_i);
    v_ack     = MaxHarts'(w_resumeack);
    v_hrst    = MaxHarts'(w_havereset);

    w_status                = '0;
    w_status.anyhalted      = any_of(v_halted, v_s);
    w_status.allhalted      = all_of(v_halted, v_s);
    w_status.anyrunning     = any_of(v_running, v_s);
    w_status.allrunning     = all_of(v_running, v_s);
    w_status.anyunavail     = any_of(v_unavail, v_s);
    w_status.allunavail     = all_of(v_unavail, v_s);
    w_status.anyresumeack   = any_of(v_ack, v_s);
    w_status.allresumeack   = all_of(v_ack, v_s);
    w_status.anyhavereset   = any_of(v_hrst, v_s);
    w_status.allhavereset   = all_of(v_hrst, v_s);
    // Nonexistence describes the hartsel target alone, not the window.
    w_status.anynonexistent = w_nonexistent;
    w_status.allnonexistent = w_nonexistent;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_status <= '0;
    end else if (w_clear) begin
      r_status <= '0;
    end else begin
      r_status <= w_status;
    end
  end

  assign status_o = r_status;

endmodule
`default_nettype wire

// File: tb/tb_dm_hart_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_hart_array
// Purpose  : Self-checking bench for dm_hart_array (4 harts, 16-cycle
//            watchdog). Combinational outputs are compared directly; the
//            registered status is queued when stimulus is driven and
//            compared on the following clock.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_hart_array;
  import dm::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         dmactive;
  logic [19:0]  hartsel;
  logic         hasel;
  logic [N-1:0] hawindow;
  logic         haltreq;
  logic         resumereq;
  logic         ackhavereset;
  logic [N-1:0] halted;
  logic [N-1:0] resuming;
  logic [N-1:0] unavailable;
  logic [N-1:0] hart_reset;
  logic [N-1:0] debug_req;
  logic [N-1:0] resumereq_out;
  logic [N-1:0] sel;
  logic         halt_timeout;
  hart_status_t status;

  always #5 clk = ~clk;

  dm_hart_array #(
    .NrHarts         (N),
    .SelectableHarts (4'b1111),
    .HaltTimeout     (16)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .dmactive_i     (dmactive),
    .hartsel_i      (hartsel),
    .hasel_i        (hasel),
    .hawindow_i     (hawindow),
    .haltreq_i      (haltreq),
    .resumereq_i    (resumereq),
    .ackhavereset_i (ackhavereset),
    .halted_i       (halted),
    .resuming_i     (resuming),
    .unavailable_i  (unavailable),
    .hart_reset_i   (hart_reset),
    .debug_req_o    (debug_req),
    .resumereq_o    (resumereq_out),
    .sel_o          (sel),
    .halt_timeout_o (halt_timeout),
    .status_o       (status)
  );

  int checks = 0;
  int errors = 0;

  // Status bit order: allhr anyhr allra anyra allne anyne allun anyun
  //                   allrun anyrun allh anyh
  typedef struct {
    string       tag;
    logic [11:0] val;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [19:0] hs;
    logic        hasel;
    logic [3:0]  win;
    logic        hr;
    logic [3:0]  halted;
    logic [3:0]  unav;
    logic [3:0]  sel;
    logic [3:0]  dbg;
    logic [11:0] st;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic push(input string tag, input logic [11:0] val);
    sb_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  // Advance one clock and compare any status expectation queued for it.
  task automatic cyc();
    sb_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, 32'(status), 32'(e.val));
    end
  endtask

  initial begin
    //          hs     hasel win      hr   halted   unav     sel      dbg      status
    vt[0] = '{20'd2, 1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 12'b0000_0000_1100};
    vt[1] = '{20'd2, 1'b0, 4'b0000, 1'b1, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 12'b0000_0000_0011};
    vt[2] = '{20'd7, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 12'b0000_1100_0000};
    vt[3] = '{20'd7, 1'b1, 4'b1011, 1'b1, 4'b0001, 4'b0000, 4'b1011, 4'b1010, 12'b0000_1100_0101};
    vt[4] = '{20'd1, 1'b0, 4'b1011, 1'b1, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 12'b0000_0011_0000};
    vt[5] = '{20'd0, 1'b1, 4'b0110, 1'b1, 4'b0000, 4'b0100, 4'b0111, 4'b0011, 12'b0000_0001_0100};
    vt[6] = '{20'd3, 1'b1, 4'b1111, 1'b0, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 12'b0000_0000_0011};
    vt[7] = '{20'd3, 1'b0, 4'b0000, 1'b1, 4'b1111, 4'b0000, 4'b1000, 4'b0000, 12'b0000_0000_0011};

    rst_n        = 1'b0;
    dmactive     = 1'b1;
    hartsel      = '0;
    hasel        = 1'b0;
    hawindow     = '0;
    haltreq      = 1'b0;
    resumereq    = 1'b0;
    ackhavereset = 1'b0;
    halted       = '0;
    resuming     = '0;
    unavailable  = '0;
    hart_reset   = '0;

    // Reset values
    #12;
    chk("reset_status", 32'(status), 32'd0);
    chk("reset_resumereq", 32'(resumereq_out), 32'd0);
    chk("reset_timeout", 32'(halt_timeout), 32'd0);
    rst_n = 1'b1;
    cyc();

    // havereset comes up set for every present hart; acknowledge it.
    hasel    = 1'b1;
    hawindow = 4'b1111;
    #1;
    chk("sel_window_all", 32'(sel), 32'h0000000f);
    push("havereset_init", 12'b1100_0000_1100);
    cyc();
    ackhavereset = 1'b1;
    push("havereset_ack_cycle", 12'b1100_0000_1100);
    cyc();
    ackhavereset = 1'b0;
    push("havereset_acked", 12'b0000_0000_1100);
    cyc();

    // Selection / halt request / status table
    for (int i = 0; i < 8; i++) begin
      hartsel     = vt[i].hs;
      hasel       = vt[i].hasel;
      hawindow    = vt[i].win;
      haltreq     = vt[i].hr;
      halted      = vt[i].halted;
      unavailable = vt[i].unav;
      #1;
      chk($sformatf("vec%0d_sel", i), 32'(sel), 32'(vt[i].sel));
      chk($sformatf("vec%0d_debug_req", i), 32'(debug_req), 32'(vt[i].dbg));
      push($sformatf("vec%0d_status", i), vt[i].st);
      cyc();
    end
    haltreq     = 1'b0;
    halted      = '0;
    unavailable = '0;
    hasel       = 1'b0;
    hawindow    = '0;
    hartsel     = '0;
    cyc();

    // Windowed resume with staggered acknowledgement
    hasel    = 1'b1;
    hawindow = 4'b1011;
    halted   = 4'b1111;
    cyc();
    resumereq = 1'b1;
    cyc();
    resumereq = 1'b0;
    chk("resume_issue", 32'(resumereq_out), 32'h0000000b);
    cyc();
    chk("resume_held", 32'(resumereq_out), 32'h0000000b);
    resuming = 4'b0011;
    halted   = 4'b1100;
    cyc();
    resuming = '0;
    chk("resume_partial", 32'(resumereq_out), 32'h00000008);
    push("ack_partial", 12'b0001_0000_0101);
    cyc();
    resuming = 4'b1000;
    halted   = 4'b0100;
    cyc();
    resuming = '0;
    chk("resume_done", 32'(resumereq_out), 32'd0);
    push("ack_all", 12'b0011_0000_1100);
    cyc();

    // Halt wins over resume; resume on a running hart does nothing
    hasel   = 1'b0;
    hartsel = 20'd1;
    halted  = 4'b0010;
    cyc();
    haltreq   = 1'b1;
    resumereq = 1'b1;
    cyc();
    haltreq   = 1'b0;
    resumereq = 1'b0;
    chk("halt_wins", 32'(resumereq_out), 32'd0);
    push("ack_kept", 12'b0011_0000_0011);
    cyc();
    hartsel   = 20'd0;
    resumereq = 1'b1;
    cyc();
    resumereq = 1'b0;
    chk("resume_running", 32'(resumereq_out), 32'd0);
    push("ack_unchanged", 12'b0011_0000_1100);
    cyc();

    // Reset-to-ack collision: set wins, lone ack then clears
    halted       = '0;
    hart_reset   = 4'b0001;
    ackhavereset = 1'b1;
    cyc();
    hart_reset = '0;
    push("havereset_set_wins", 12'b1111_0000_1100);
    cyc();
    ackhavereset = 1'b0;
    push("havereset_cleared", 12'b0011_0000_1100);
    cyc();

    // Watchdog: hart 2 never halts
    hartsel = 20'd2;
    haltreq = 1'b1;
    #1;
    chk("wd_debug_req", 32'(debug_req), 32'h00000004);
    for (int k = 1; k <= 19; k++) begin
      cyc();
      if (k == 15) chk("wd_not_yet", 32'(halt_timeout), 32'd0);
      if (k == 16) chk("wd_fire", 32'(halt_timeout), 32'd1);
      if (k == 19) chk("wd_sticky", 32'(halt_timeout), 32'd1);
    end
    haltreq = 1'b0;
    cyc();
    chk("wd_clear", 32'(halt_timeout), 32'd0);

    // dmactive low while a resume is pending
    hasel    = 1'b1;
    hawindow = 4'b0001;
    hartsel  = 20'd0;
    halted   = 4'b0001;
    cyc();
    resumereq = 1'b1;
    cyc();
    resumereq = 1'b0;
    chk("pend_before_clear", 32'(resumereq_out), 32'h00000001);
    dmactive = 1'b0;
    haltreq  = 1'b1;
    hasel    = 1'b0;
    hartsel  = 20'd1;
    #1;
    chk("debug_req_gated", 32'(debug_req), 32'd0);
    push("status_cleared", 12'b0000_0000_0000);
    cyc();
    chk("pend_cleared", 32'(resumereq_out), 32'd0);
    dmactive = 1'b1;
    haltreq  = 1'b0;
    push("havereset_after_clear", 12'b1100_0000_1100);
    cyc();

    // Asynchronous reset in the middle of a stuck halt
    halted  = '0;
    hartsel = 20'd2;
    haltreq = 1'b1;
    for (int k = 0; k < 17; k++) cyc();
    chk("timeout_before_reset", 32'(halt_timeout), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_status", 32'(status), 32'd0);
    chk("async_reset_timeout", 32'(halt_timeout), 32'd0);
    chk("async_reset_resumereq", 32'(resumereq_out), 32'd0);
    haltreq = 1'b0;
    #3;
    rst_n = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
